// File: rtl/muldiv_e_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes,
// FSM state encoding, default latencies and small op-class helpers.
package muldiv_e_pkg;

    // Operation codes presented on the op input
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    // Default busy periods and latency counter width
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;
    localparam int CNT_W        = 4;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit product and quotient/remainder datapath.
// Division is done on magnitudes and the signs are restored afterwards, so
// 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
module md_calc
    import muldiv_e_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               signed_div;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        quot;
    logic [31:0]        rem;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign signed_div = (op == OP_DIV);
    assign a_neg      = signed_div & a[31];
    assign b_neg      = signed_div & b[31];
    assign a_mag      = a_neg ? (32'd0 - a) : a;
    assign b_mag      = b_neg ? (32'd0 - b) : b;
    assign div_zero   = is_div_op(op) && (b == 32'd0);

    // Unsigned magnitude divide; guarded so a zero divisor never reaches the divider
    always_comb begin
        q_mag = 32'd0;
        r_mag = 32'd0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
    end

    // Quotient truncates toward zero; remainder follows the dividend's sign
    assign quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem  = a_neg ? (32'd0 - r_mag) : r_mag;

    // Select the HI/LO pair for the requested operation
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                res_hi = rem;
                res_lo = quot;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_e.sv
// E-stage HI/LO unit: control FSM, latency counter, operand latches and
// the architectural HI/LO registers. Arithmetic lives in md_calc.
module muldiv_e
    import muldiv_e_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [31:0]        calc_hi;
    logic [31:0]        calc_lo;
    logic               calc_div_zero;

    md_calc u_calc (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .res_hi   (calc_hi),
        .res_lo   (calc_lo),
        .div_zero (calc_div_zero)
    );

    // State, counter, operand latches and HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state logic: accept ops only in IDLE, commit results on the last busy cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul_op(op)) begin
                        op_d    = op;
                        a_d     = rs_data;
                        b_d     = rt_data;
                        cnt_d   = CNT_W'(MULT_CYC);
                        state_d = ST_MUL;
                    end else if (is_div_op(op)) begin
                        op_d    = op;
                        a_d     = rs_data;
                        b_d     = rt_data;
                        cnt_d   = CNT_W'(DIV_CYC);
                        state_d = ST_DIV;
                    end else if (op == OP_MTHI) begin
                        hi_d = rs_data;
                    end else if (op == OP_MTLO) begin
                        lo_d = rs_data;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    // A zero divisor still burns the full period but commits nothing
                    if (!calc_div_zero) begin
                        hi_d = calc_hi;
                        lo_d = calc_lo;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_e.sv
// Self-checking bench for muldiv_e: directed scenarios followed by random
// operations, all compared against an arithmetic reference model.
module tb_muldiv_e;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    muldiv_e #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    // Reference: apply an op to the architectural HI/LO using plain arithmetic
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      x, y, q, r;
        logic [63:0] p;
        case (o)
            3'd0: begin
                x = longint'($signed(a));
                y = longint'($signed(b));
                p = 64'(x * y);
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            3'd1: begin
                p = 64'(a) * 64'(b);
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            3'd2: if (b != 0) begin
                x = longint'($signed(a));
                y = longint'($signed(b));
                q = x / y;
                r = x % y;
                exp_lo = q[31:0];
                exp_hi = r[31:0];
            end
            3'd3: if (b != 0) begin
                exp_lo = a / b;
                exp_hi = a % b;
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    // Called at a negedge: issue a mul/div, optionally poke a start during busy
    // cycle intf_at (0-based), check busy width and HI/LO hold, then the result.
    task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int intf_at, input logic [2:0] intf_op, input logic [31:0] intf_rs);
        int n;
        n = (o <= 3'd1) ? MC : DC;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("busy_c%0d op%0d", i, o), {31'd0, busy}, 32'd1);
            chk($sformatf("hold_hi_c%0d", i), hi, exp_hi);
            chk($sformatf("hold_lo_c%0d", i), lo, exp_lo);
            start   = (i == intf_at);
            op      = (i == intf_at) ? intf_op : 3'($urandom_range(0, 7));
            rs_data = (i == intf_at) ? intf_rs : $urandom;
            rt_data = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        model(o, a, b);
        chk($sformatf("done_busy op%0d", o), {31'd0, busy}, 32'd0);
        chk($sformatf("res_hi op%0d a=%08h b=%08h", o, a, b), hi, exp_hi);
        chk($sformatf("res_lo op%0d a=%08h b=%08h", o, a, b), lo, exp_lo);
        $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h", o, a, b, hi, lo);
    endtask

    // Called at a negedge: one-cycle op that must not raise busy
    task automatic run_single(input logic [2:0] o, input logic [31:0] a);
        start = 1'b1; op = o; rs_data = a; rt_data = $urandom;
        @(negedge clk);
        start = 1'b0;
        model(o, a, 32'd0);
        chk($sformatf("single_busy op%0d", o), {31'd0, busy}, 32'd0);
        chk($sformatf("single_hi op%0d", o), hi, exp_hi);
        chk($sformatf("single_lo op%0d", o), lo, exp_lo);
        $display("op=%0d rs=%08h -> hi=%08h lo=%08h", o, a, hi, lo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b0; start = 1'b0; op = 3'd0; rs_data = 32'd0; rt_data = 32'd0;
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Signed and unsigned multiply corner cases
        run_md(3'd0, 32'hFFFFFFFE, 32'd3, -1, 3'd0, 32'd0);
        chk("mult_const_hi", hi, 32'hFFFFFFFF);
        chk("mult_const_lo", lo, 32'hFFFFFFFA);
        run_md(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 3'd0, 32'd0);
        chk("multu_const_hi", hi, 32'hFFFFFFFE);
        chk("multu_const_lo", lo, 32'h00000001);

        // Signed divide, then divide by zero leaves HI/LO alone
        run_md(3'd2, 32'hFFFFFFF9, 32'd2, -1, 3'd0, 32'd0);
        chk("div_const_hi", hi, 32'hFFFFFFFF);
        chk("div_const_lo", lo, 32'hFFFFFFFD);
        run_md(3'd3, 32'd7, 32'd0, -1, 3'd0, 32'd0);
        chk("divu0_hi", hi, 32'hFFFFFFFF);
        chk("divu0_lo", lo, 32'hFFFFFFFD);

        // Overflowing signed divide
        run_md(3'd2, 32'h80000000, 32'hFFFFFFFF, -1, 3'd0, 32'd0);
        chk("div_ovf_hi", hi, 32'd0);
        chk("div_ovf_lo", lo, 32'h80000000);

        // MTLO during busy is dropped; MTLO in IDLE takes effect
        run_md(3'd0, 32'd1000, 32'd77, 1, 3'd5, 32'h1234);
        chk("mtlo_ignored", lo, 32'd77000);
        run_single(3'd5, 32'h1234);
        chk("mtlo_idle", lo, 32'h1234);
        run_single(3'd4, 32'hCAFEF00D);

        // Unrecognised op codes change nothing
        run_single(3'd6, 32'hDEADBEEF);
        run_single(3'd7, 32'h5A5A5A5A);

        // Reset in the third busy cycle of a DIV discards the result
        start = 1'b1; op = 3'd2; rs_data = 32'd100; rt_data = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_hi", hi, 32'd0);
        chk("async_rst_lo", lo, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        // Start on the very first edge after reset release
        run_md(3'd0, 32'd3, 32'd4, -1, 3'd0, 32'd0);
        chk("post_reset_lo", lo, 32'd12);

        // Random mix, with occasional zero divisors and stray starts while busy
        for (int k = 0; k < 40; k++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
            if (ro >= 3'd4)
                run_single(ro, ra);
            else
                run_md(ro, ra, rb, int'($urandom_range(0, 4)), 3'($urandom_range(0, 7)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_e.md
MULDIV_E -- requirements
Module: muldiv_e

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5, meaning busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYC, default 10, meaning busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1, E-stage instruction is a valid mul/div/mt op this cycle.
REQ-006 SHALL have port op, input, 3, operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 SHALL have port rs_data, input, 32, the forwarded E-stage RS operand.
REQ-008 SHALL have port rt_data, input, 32, the forwarded E-stage RT operand.
REQ-009 SHALL have port busy, output, 1, a multi-cycle operation is in progress.
REQ-010 SHALL have port hi, output, 32, the architectural HI register.
REQ-011 SHALL have port lo, output, 32, the architectural LO register.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, plus a 4-bit down-counter.
REQ-013 In IDLE, start=1 with MULT/MULTU SHALL latch operands, load counter=MULT_CYC, and enter MUL at the next edge.
REQ-014 In IDLE, start=1 with DIV/DIVU SHALL latch operands, load counter=DIV_CYC, and enter DIV at the next edge.
REQ-015 busy SHALL be 1 exactly while state is MUL or DIV: MULT_CYC or DIV_CYC cycles after the start edge.
REQ-016 In MUL/DIV the counter SHALL decrement each cycle; at count 1 the next edge SHALL write HI/LO, return to IDLE, and deassert busy.
REQ-017 New hi/lo SHALL be visible in the first cycle busy=0; hi/lo SHALL hold their old values while busy=1.
REQ-018 MULT SHALL compute the signed 64-bit rs*rt; MULTU SHALL compute the unsigned 64-bit rs*rt; hi=[63:32], lo=[31:0].
REQ-019 DIV SHALL produce a signed quotient truncated toward zero in lo and a remainder in hi carrying the sign of the dividend (rs).
REQ-020 DIVU SHALL produce the unsigned quotient in lo and the remainder in hi.
REQ-021 For division by zero (rt=0), the block SHALL run the full DIV_CYC busy period and leave hi/lo unchanged.
REQ-022 For DIV with 0x80000000 / 0xFFFFFFFF, the block SHALL give lo=0x80000000 and hi=0.
REQ-023 MTHI/MTLO in IDLE SHALL write rs_data to hi/lo at the next edge, with no busy assertion.
REQ-024 start during MUL/DIV SHALL be ignored, and the in-flight operation SHALL be unaffected; the hazard unit stalls such instructions using start|busy.
REQ-025 Operands SHALL be sampled only at the start edge; later changes on rs_data/rt_data SHALL have no effect.
REQ-026 An unrecognised op with start=1 SHALL leave all state unchanged.

Reset
REQ-027 reset=0 SHALL asynchronously force state=IDLE, counter=0, busy=0, hi=0, lo=0, including mid-operation; the pending result SHALL be discarded.
REQ-028 On the first edge after reset rises, start SHALL be honoured normally.

Structure
REQ-029 The op encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5), the state encoding, and the default latencies SHALL live in the shared CPU package/header.
REQ-030 The 64-bit product and quotient/remainder arithmetic SHALL be one combinational sub-module, md_calc.
REQ-031 muldiv_e SHALL hold only the FSM, counter, operand latches, and HI/LO.

Verification
REQ-032 Bench SHALL drive MULT rs=0xFFFFFFFE, rt=3 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 Bench SHALL drive MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 Bench SHALL drive DIV rs=-7, rt=2 -> busy=1 for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU 7/0 -> hi/lo unchanged after 10 cycles.
REQ-035 Bench SHALL drive MULT and then MTLO rs=0x1234 on cycle 2 of busy -> MTLO ignored, final lo equals the product; with a following MTLO in IDLE -> lo=0x1234 next cycle, busy stays 0.
REQ-036 Bench SHALL pulse reset low during cycle 3 of a DIV -> busy=0 and hi=lo=0 immediately; a later MULT 3*4 -> lo=12 after 5 cycles.
